// File: rtl/div16x8.sv
// Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor.
// One quotient bit per clock; start/done handshake and state codes match the 8x8 multiplier.
module div16x8 (
    input  logic        clk,
    input  logic        aclr_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        done_flag,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        CALC = 3'b001,
        DONE = 3'b100,
        ERR  = 3'b101
    } state_t;

    state_t      r_state, w_stateNext;
    logic [15:0] r_q, w_qNext;
    logic [7:0]  r_r, w_rNext;
    logic [7:0]  r_d, w_dNext;
    logic [3:0]  r_cnt, w_cntNext;
    logic [15:0] r_quotient, w_quotientNext;
    logic [7:0]  r_remainder, w_remainderNext;
    logic        r_dbz, w_dbzNext;

    logic [8:0]  w_t;
    logic        w_ge;
    logic [7:0]  w_diff;
    logic [7:0]  w_rIter;
    logic [15:0] w_qShift;

    // The partial remainder stays below the divisor between iterations, so its
    // ninth bit is always zero and only the trial value needs nine bits.
    assign w_t      = {r_r, r_q[15]};
    assign w_ge     = (w_t >= {1'b0, r_d});
    assign w_diff   = w_t[7:0] - r_d;
    assign w_rIter  = w_ge ? w_diff : w_t[7:0];
    assign w_qShift = {r_q[14:0], w_ge};

    always_comb begin
        w_stateNext     = r_state;
        w_qNext         = r_q;
        w_rNext         = r_r;
        w_dNext         = r_d;
        w_cntNext       = r_cnt;
        w_quotientNext  = r_quotient;
        w_remainderNext = r_remainder;
        w_dbzNext       = r_dbz;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (divisor == 8'd0) begin
                        w_stateNext     = DONE;
                        w_quotientNext  = 16'hFFFF;
                        w_remainderNext = dividend[7:0];
                        w_dbzNext       = 1'b1;
                    end else begin
                        w_stateNext = CALC;
                        w_qNext     = dividend;
                        w_rNext     = 8'd0;
                        w_dNext     = divisor;
                        w_cntNext   = 4'd0;
                    end
                end
            end
            CALC: begin
                // A fresh start while busy abandons the operation without touching the results.
                if (start) begin
                    w_stateNext = ERR;
                end else begin
                    w_qNext   = w_qShift;
                    w_rNext   = w_rIter;
                    w_cntNext = r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        w_stateNext     = DONE;
                        w_quotientNext  = w_qShift;
                        w_remainderNext = w_rIter;
                        w_dbzNext       = 1'b0;
                    end
                end
            end
            DONE: w_stateNext = IDLE;
            ERR: begin
                if (!start) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state     <= IDLE;
            r_q         <= 16'd0;
            r_r         <= 8'd0;
            r_d         <= 8'd0;
            r_cnt       <= 4'd0;
            r_quotient  <= 16'd0;
            r_remainder <= 8'd0;
            r_dbz       <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_q         <= w_qNext;
            r_r         <= w_rNext;
            r_d         <= w_dNext;
            r_cnt       <= w_cntNext;
            r_quotient  <= w_quotientNext;
            r_remainder <= w_remainderNext;
            r_dbz       <= w_dbzNext;
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign done_flag   = (r_state == DONE);
    assign state_out   = r_state;

endmodule

// File: tb/tb_div16x8.sv
// Self-checking bench for div16x8: directed cases from the test plan plus random
// operands compared against plain integer division.
module tb_div16x8;

    logic        clk;
    logic        aclr_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        done_flag;
    logic [2:0]  state_out;

    int checks;
    int failures;
    logic [15:0] prevQ;
    logic [7:0]  prevR;
    logic        prevDbz;

    div16x8 dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .done_flag   (done_flag),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one full divide and checks timing, state codes and results against integer arithmetic.
    task automatic applyStimulus(input logic [15:0] dd, input logic [7:0] dv);
        int n;
        logic [15:0] expQ;
        logic [7:0]  expR;
        if (dv == 8'd0) begin
            expQ = 16'hFFFF;
            expR = dd[7:0];
        end else begin
            expQ = 16'(int'(dd) / int'(dv));
            expR = 8'(int'(dd) % int'(dv));
        end
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        if (dv == 8'd0) begin
            checkOutput("dbzState", state_out, 3'b100);
            checkOutput("dbzDone", done_flag, 1'b1);
        end else begin
            checkOutput("acceptState", state_out, 3'b001);
            n = 0;
            while (n < 40) begin
                @(posedge clk);
                #1;
                n++;
                if (done_flag) break;
                checkOutput("calcState", state_out, 3'b001);
                if (n == 8) begin
                    checkOutput("holdQ", quotient, prevQ);
                    checkOutput("holdR", remainder, prevR);
                end
            end
            checkOutput("latency", n, 16);
            checkOutput("doneState", state_out, 3'b100);
        end
        checkOutput("quotient", quotient, expQ);
        checkOutput("remainder", remainder, expR);
        checkOutput("divByZero", div_by_zero, (dv == 8'd0));
        @(posedge clk);
        #1;
        checkOutput("backToIdle", state_out, 3'b000);
        checkOutput("donePulseEnd", done_flag, 1'b0);
        prevQ   = expQ;
        prevR   = expR;
        prevDbz = (dv == 8'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        aclr_n   = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        prevQ    = 16'd0;
        prevR    = 8'd0;
        prevDbz  = 1'b0;

        #12;
        checkOutput("rstQuotient", quotient, 16'h0000);
        checkOutput("rstRemainder", remainder, 8'h00);
        checkOutput("rstDbz", div_by_zero, 1'b0);
        checkOutput("rstDone", done_flag, 1'b0);
        checkOutput("rstState", state_out, 3'b000);
        @(negedge clk);
        aclr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idleNoStart", state_out, 3'b000);

        $display("[TB] directed cases");
        applyStimulus(16'h03E8, 8'h07);
        applyStimulus(16'hFFFF, 8'hFF);
        applyStimulus(16'hFFFF, 8'h01);
        applyStimulus(16'h0005, 8'h09);
        applyStimulus(16'h1234, 8'h00);

        $display("[TB] abort during CALC");
        @(negedge clk);
        dividend = 16'h4321;
        divisor  = 8'h05;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abortState", state_out, 3'b101);
            checkOutput("abortNoDone", done_flag, 1'b0);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abortIdle", state_out, 3'b000);
        checkOutput("abortNoDone2", done_flag, 1'b0);
        checkOutput("abortKeepQ", quotient, prevQ);
        checkOutput("abortKeepR", remainder, prevR);
        checkOutput("abortKeepDbz", div_by_zero, prevDbz);

        $display("[TB] reset mid-CALC");
        @(negedge clk);
        dividend = 16'h9999;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        aclr_n = 1'b0;
        #1;
        checkOutput("midRstQuotient", quotient, 16'h0000);
        checkOutput("midRstRemainder", remainder, 8'h00);
        checkOutput("midRstDbz", div_by_zero, 1'b0);
        checkOutput("midRstDone", done_flag, 1'b0);
        checkOutput("midRstState", state_out, 3'b000);
        prevQ   = 16'd0;
        prevR   = 8'd0;
        prevDbz = 1'b0;
        @(negedge clk);
        aclr_n = 1'b1;
        applyStimulus(16'h00FF, 8'h10);

        $display("[TB] random operands");
        for (int i = 0; i < 24; i++) begin
            logic [15:0] rdd;
            logic [7:0]  rdv;
            rdd = 16'($urandom);
            rdv = (i % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            applyStimulus(rdd, rdv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
